// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared codes, channel indices and state type for the UART command decoder
package uart_cmd_pkg;

  // Default received-byte codes for each command channel
  localparam logic [7:0] CMD_RIGHT   = 8'h02;
  localparam logic [7:0] CMD_LEFT    = 8'h00;
  localparam logic [7:0] CMD_DOWN    = 8'h05;
  localparam logic [7:0] CMD_UP      = 8'h03;
  localparam logic [7:0] CMD_TRIGGER = 8'h06;

  // Channel positions inside o_cmd and the packed code table
  localparam int CH_RIGHT   = 0;
  localparam int CH_LEFT    = 1;
  localparam int CH_DOWN    = 2;
  localparam int CH_UP      = 3;
  localparam int CH_TRIGGER = 4;

  localparam int          NUM_CMDS_DEF   = 5;
  localparam logic [4:0]  PULSE_MASK_DEF = 5'b10000;

  // IDLE: no held channel; HOLD: exactly one held channel asserted
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/uart_cmd_match.sv
// rtl/uart_cmd_match.sv - combinational priority matcher of a received byte against the code table
module uart_cmd_match #(
  parameter int                         DATA_W    = 8,
  parameter int                         NUM_CMDS  = 5,
  parameter int                         IDX_W     = 3,
  parameter logic [NUM_CMDS*DATA_W-1:0] CMD_CODES = '0
) (
  input  logic [DATA_W-1:0] i_data,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  // Scan from the top slice down so the lowest matching index is the last one written
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = NUM_CMDS - 1; k >= 0; k--) begin
      if (i_data == CMD_CODES[k*DATA_W +: DATA_W]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_decode.sv
// rtl/uart_cmd_decode.sv - registered UART byte to command-channel decoder with hold timeout
module uart_cmd_decode
  import uart_cmd_pkg::*;
#(
  parameter int                         DATA_W      = 8,
  parameter int                         NUM_CMDS    = NUM_CMDS_DEF,
  parameter logic [NUM_CMDS*DATA_W-1:0] CMD_CODES   = {CMD_TRIGGER, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT},
  parameter logic [NUM_CMDS-1:0]        PULSE_MASK  = PULSE_MASK_DEF,
  parameter int unsigned                HOLD_CYCLES = 1000000,
  parameter int                         HOLD_W      = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_done,
  input  logic [DATA_W-1:0]   i_data,
  output logic [NUM_CMDS-1:0] o_cmd,
  output logic                o_valid,
  output logic                o_unknown,
  output logic                o_active
);

  localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_cnt;
  logic [NUM_CMDS-1:0] r_cmd;
  logic                r_valid;
  logic                r_unknown;

  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   w_cnt_nxt;
  logic [NUM_CMDS-1:0] w_held_nxt;
  logic [NUM_CMDS-1:0] w_pulse_nxt;
  logic                w_valid_nxt;
  logic                w_unknown_nxt;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic [NUM_CMDS-1:0] w_onehot;

  uart_cmd_match #(
    .DATA_W    (DATA_W),
    .NUM_CMDS  (NUM_CMDS),
    .IDX_W     (IDX_W),
    .CMD_CODES (CMD_CODES)
  ) u_match (
    .i_data (i_data),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_onehot = NUM_CMDS'(1) << w_idx;

  // Next-state: timeout bookkeeping first, then a new byte overrides it (new byte wins on expiry)
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_held_nxt    = r_cmd & ~PULSE_MASK;
    w_pulse_nxt   = '0;
    w_valid_nxt   = 1'b0;
    w_unknown_nxt = 1'b0;

    if (r_state == HOLD && HOLD_CYCLES != 0) begin
      if (r_cnt <= HOLD_W'(1)) begin
        w_held_nxt  = '0;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - HOLD_W'(1);
      end
    end

    if (i_done) begin
      if (w_hit) begin
        w_valid_nxt = 1'b1;
        if (PULSE_MASK[w_idx]) begin
          // Pulse channels ride on top of whatever hold is running
          w_pulse_nxt = w_onehot;
        end else begin
          w_held_nxt  = w_onehot;
          w_state_nxt = HOLD;
          w_cnt_nxt   = HOLD_W'(HOLD_CYCLES);
        end
      end else begin
        // Unrecognised byte is treated as a safety stop
        w_unknown_nxt = 1'b1;
        w_held_nxt    = '0;
        w_state_nxt   = IDLE;
        w_cnt_nxt     = '0;
      end
    end
  end

  // State, counter and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_valid   <= 1'b0;
      r_unknown <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cmd     <= w_held_nxt | w_pulse_nxt;
      r_valid   <= w_valid_nxt;
      r_unknown <= w_unknown_nxt;
    end
  end

  assign o_cmd     = r_cmd;
  assign o_valid   = r_valid;
  assign o_unknown = r_unknown;
  assign o_active  = (r_state == HOLD);

endmodule

// File: tb/tb_uart_cmd_decode.sv
// tb/tb_uart_cmd_decode.sv - self-checking bench for uart_cmd_decode with reference model
module tb_uart_cmd_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic [7:0] data;

  logic [4:0] cmd_a, cmd_b;
  logic       valid_a, valid_b, unk_a, unk_b, act_a, act_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance A: default codes, 4-cycle hold
  uart_cmd_decode #(.HOLD_CYCLES(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_done(done), .i_data(data),
    .o_cmd(cmd_a), .o_valid(valid_a), .o_unknown(unk_a), .o_active(act_a)
  );

  // Instance B: infinite hold, slice 3 duplicates slice 0 to exercise lowest-index priority
  uart_cmd_decode #(.HOLD_CYCLES(0), .CMD_CODES({8'h06, 8'h02, 8'h05, 8'h00, 8'h02})) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_done(done), .i_data(data),
    .o_cmd(cmd_b), .o_valid(valid_b), .o_unknown(unk_b), .o_active(act_b)
  );

  // Reference model: which channel is held, how many cycles it still has, and this cycle's strobes
  int m_code [2][5] = '{'{8'h02, 8'h00, 8'h05, 8'h03, 8'h06}, '{8'h02, 8'h00, 8'h05, 8'h02, 8'h06}};
  int m_hold [2]    = '{4, 0};
  int m_held [2]    = '{-1, -1};
  int m_rem  [2]    = '{0, 0};
  int m_pulse[2]    = '{-1, -1};
  bit m_valid[2], m_unk[2];
  bit m_ready = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_held[u] = -1; m_rem[u] = 0; m_pulse[u] = -1; m_valid[u] = 0; m_unk[u] = 0;
      end else begin
        int k;
        m_pulse[u] = -1; m_valid[u] = 0; m_unk[u] = 0;
        if (m_held[u] >= 0 && m_hold[u] > 0) begin
          m_rem[u]--;
          if (m_rem[u] == 0) m_held[u] = -1;
        end
        if (done) begin
          k = -1;
          for (int j = 4; j >= 0; j--) if (int'(data) == m_code[u][j]) k = j;
          if (k < 0) begin
            m_unk[u] = 1; m_held[u] = -1; m_rem[u] = 0;
          end else begin
            m_valid[u] = 1;
            if (k == 4) m_pulse[u] = k;
            else begin m_held[u] = k; m_rem[u] = m_hold[u]; end
          end
        end
      end
    end
    m_ready = 1;
  end

  task automatic check_inst(input int u, input logic [4:0] c, input logic v, input logic n, input logic a);
    logic [4:0] e;
    e = '0;
    if (m_held[u] >= 0) e[m_held[u]] = 1'b1;
    if (m_pulse[u] >= 0) e[m_pulse[u]] = 1'b1;
    chk($sformatf("model_cmd[%0d]", u), int'(c), int'(e));
    chk($sformatf("model_valid[%0d]", u), int'(v), int'(m_valid[u]));
    chk($sformatf("model_unknown[%0d]", u), int'(n), int'(m_unk[u]));
    chk($sformatf("model_active[%0d]", u), int'(a), (m_held[u] >= 0) ? 1 : 0);
  endtask

  // Compare both instances against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_ready) begin
      check_inst(0, cmd_a, valid_a, unk_a, act_a);
      check_inst(1, cmd_b, valid_b, unk_b, act_b);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    done = 1'b1;
    data = d;
    cyc();
    done = 1'b0;
  endtask

  task automatic count_a(input int bitpos, output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_a[bitpos]) n++;
      cyc();
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; done = 1'b1; data = 8'h02;

    // Reset with a live strobe: everything must stay low
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_cmd", int'(cmd_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_active", int'(act_a), 0);
    end
    rst_n = 1'b1; done = 1'b0;
    cyc();
    chk("post_rst_active", int'(act_a), 0);

    // Held channel with 4-cycle timeout
    send(8'h02);
    chk("hold_cmd", int'(cmd_a), 5'b00001);
    chk("hold_valid", int'(valid_a), 1);
    chk("hold_active", int'(act_a), 1);
    count_a(0, n);
    chk("hold_len", n, 4);
    chk("hold_end_cmd", int'(cmd_a), 0);
    chk("hold_end_active", int'(act_a), 0);

    // Replace 02 by 03, then repeat 03 while its count is 1
    send(8'h02);
    cyc();
    chk("repl_before", int'(cmd_a), 5'b00001);
    send(8'h03);
    chk("repl_after", int'(cmd_a), 5'b01000);
    cyc(); cyc(); cyc();
    chk("repl_last", int'(cmd_a), 5'b01000);
    send(8'h03);
    chk("restart_nogap", int'(cmd_a), 5'b01000);
    count_a(3, n);
    chk("restart_len", n, 4);

    // Trigger pulse on top of a hold; hold timing unchanged
    send(8'h05);
    cyc();
    send(8'h06);
    chk("pulse_over_hold", int'(cmd_a), 5'b10100);
    chk("pulse_valid", int'(valid_a), 1);
    cyc();
    chk("pulse_gone", int'(cmd_a), 5'b00100);
    cyc();
    chk("pulse_hold_end", int'(cmd_a), 0);

    // Unknown byte stops a hold
    send(8'h02);
    cyc();
    send(8'h7F);
    chk("unk_pulse", int'(unk_a), 1);
    chk("unk_cmd", int'(cmd_a), 0);
    chk("unk_active", int'(act_a), 0);
    cyc();
    chk("unk_once", int'(unk_a), 0);

    // New byte on the exact expiry cycle
    send(8'h02);
    cyc(); cyc(); cyc();
    send(8'h00);
    chk("expiry_collide", int'(cmd_a), 5'b00010);
    count_a(1, n);
    chk("expiry_len", n, 4);

    // Infinite hold on instance B, then unknown, then reset mid-hold
    send(8'h00);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cmd_b == 5'b00010) n++;
      cyc();
    end
    chk("inf_hold_len", n, 1000);
    send(8'h7F);
    chk("inf_unk_cmd", int'(cmd_b), 0);
    send(8'h02);
    chk("dup_lowest_wins", int'(cmd_b), 5'b00001);
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("rst_mid_cmd", int'(cmd_b), 0);
    chk("rst_mid_active", int'(act_b), 0);
    rst_n = 1'b1;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      done = ($urandom_range(0, 2) == 0);
      case (sel)
        0: data = 8'h02; 1: data = 8'h00; 2: data = 8'h05; 3: data = 8'h03;
        4: data = 8'h06; 5: data = 8'h7F; default: data = 8'($urandom);
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end
    done = 1'b0; rst_n = 1'b1;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
